// File: rtl/btc_dec_buf_sched_pkg.sv
// Shared bank-state encodings and defaults for the BTC decoder buffer scheduler.
package btc_dec_buf_sched_pkg;

    typedef enum logic {
        IB_FREE = 1'b0,
        IB_FULL = 1'b1
    } ibank_state_e;

    typedef enum logic [1:0] {
        OB_FREE    = 2'd0,
        OB_WRITING = 2'd1,
        OB_FULL    = 2'd2
    } obank_state_e;

    localparam int IB_SW     = 1;
    localparam int OB_SW     = 2;
    localparam int TAG_W_DEF = 16;

endpackage

// File: rtl/btc_dec_buf_sched_bank_ring.sv
// Bank ring: per-bank state array, head/tail pointers and occupancy counter.
// Head may rewrite its bank without advancing; tail always advances when it writes.
module btc_bank_ring #(
    parameter int NUM = 2,
    parameter int SW  = 1
) (
    input  logic                    iclk,
    input  logic                    ireset_n,
    input  logic                    iclkena,
    input  logic                    i_hd_we,
    input  logic                    i_hd_adv,
    input  logic [SW-1:0]           i_hd_val,
    input  logic                    i_tl_adv,
    input  logic [SW-1:0]           i_tl_val,
    output logic [$clog2(NUM)-1:0]  o_hd_ptr,
    output logic [$clog2(NUM)-1:0]  o_tl_ptr,
    output logic [SW-1:0]           o_hd_state,
    output logic [SW-1:0]           o_tl_state,
    output logic [$clog2(NUM):0]    o_cnt
);

    localparam int PW = $clog2(NUM);

    logic [SW-1:0] r_state [NUM];
    logic [PW-1:0] r_hd;
    logic [PW-1:0] r_tl;
    logic [PW:0]   r_cnt;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(NUM - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            for (int i = 0; i < NUM; i++) r_state[i] <= '0;
            r_hd  <= '0;
            r_tl  <= '0;
            r_cnt <= '0;
        end else if (iclkena) begin
            // Head and tail writes never target the same bank in the same cycle:
            // each requires a different current state of that bank.
            if (i_hd_we)  r_state[r_hd] <= i_hd_val;
            if (i_tl_adv) r_state[r_tl] <= i_tl_val;
            if (i_hd_adv) r_hd <= nxt(r_hd);
            if (i_tl_adv) r_tl <= nxt(r_tl);
            case ({i_hd_adv, i_tl_adv})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_hd_ptr   = r_hd;
    assign o_tl_ptr   = r_tl;
    assign o_hd_state = r_state[r_hd];
    assign o_tl_state = r_state[r_tl];
    assign o_cnt      = r_cnt;

endmodule

// File: rtl/btc_dec_buf_sched.sv
// Ping-pong bank scheduler between sample writer, decoder controller and output reader.
// Input ring: head = writer, tail = decoder. Output ring: head = decoder, tail = reader.
module btc_dec_buf_sched
    import btc_dec_buf_sched_pkg::*;
#(
    parameter int pIBANK_NUM = 2,
    parameter int pOBANK_NUM = 2,
    parameter int pTAG_W     = TAG_W_DEF
) (
    input  logic                          iclk,
    input  logic                          ireset_n,
    input  logic                          iclkena,
    output logic                          owr_rdy,
    output logic [$clog2(pIBANK_NUM)-1:0] owr_bank,
    input  logic                          iwr_done,
    input  logic [pTAG_W-1:0]             iwr_tag,
    output logic                          orbuf_full,
    output logic [$clog2(pIBANK_NUM)-1:0] odec_ibank,
    output logic [$clog2(pOBANK_NUM)-1:0] odec_obank,
    output logic [pTAG_W-1:0]             odec_tag,
    output logic                          owbuf_empty,
    input  logic                          irbuf_rempty,
    output logic                          ord_val,
    output logic [$clog2(pOBANK_NUM)-1:0] ord_bank,
    output logic [pTAG_W-1:0]             ord_tag,
    input  logic                          ird_done,
    output logic                          oerr,
    output logic [$clog2(pIBANK_NUM):0]   oicnt
);

    localparam int IPW = $clog2(pIBANK_NUM);
    localparam int OPW = $clog2(pOBANK_NUM);

    logic [IPW-1:0]   w_wr_ptr;
    logic [IPW-1:0]   w_idec_ptr;
    logic [OPW-1:0]   w_odec_ptr;
    logic [OPW-1:0]   w_rd_ptr;
    logic [IB_SW-1:0] w_ib_hd_state;
    logic [IB_SW-1:0] w_ib_tl_state;
    logic [OB_SW-1:0] w_ob_hd_state;
    logic [OB_SW-1:0] w_ob_tl_state;
    logic [IPW:0]     w_icnt;
    logic [OPW:0]     w_ocnt;

    logic w_wr_rdy;
    logic w_rbuf_full;
    logic w_rd_val;
    logic w_wr_acc;
    logic w_dec_acc;
    logic w_rd_acc;
    logic w_claim;
    logic w_ob_hd_we;
    logic [OB_SW-1:0] w_ob_hd_val;

    logic [pTAG_W-1:0] r_itag [pIBANK_NUM];
    logic [pTAG_W-1:0] r_otag [pOBANK_NUM];
    logic              r_err;

    assign w_wr_rdy    = (w_ib_hd_state == IB_FREE);
    assign w_rbuf_full = (w_ib_tl_state == IB_FULL) && (w_ob_hd_state == OB_WRITING);
    assign w_rd_val    = (w_ob_tl_state == OB_FULL);

    assign w_wr_acc  = iwr_done && w_wr_rdy;
    assign w_dec_acc = irbuf_rempty && w_rbuf_full;
    assign w_rd_acc  = ird_done && w_rd_val;

    // Reserve the output bank one cycle after its input block becomes FULL, so the
    // decoder only ever sees irbuf_full with a destination already owned.
    assign w_claim     = (w_ib_tl_state == IB_FULL) && (w_ob_hd_state == OB_FREE)
                         && (w_ocnt < (OPW+1)'(pOBANK_NUM));
    assign w_ob_hd_we  = w_claim || w_dec_acc;
    assign w_ob_hd_val = w_dec_acc ? OB_FULL : OB_WRITING;

    btc_bank_ring #(
        .NUM (pIBANK_NUM),
        .SW  (IB_SW)
    ) u_iring (
        .iclk       (iclk),
        .ireset_n   (ireset_n),
        .iclkena    (iclkena),
        .i_hd_we    (w_wr_acc),
        .i_hd_adv   (w_wr_acc),
        .i_hd_val   (IB_FULL),
        .i_tl_adv   (w_dec_acc),
        .i_tl_val   (IB_FREE),
        .o_hd_ptr   (w_wr_ptr),
        .o_tl_ptr   (w_idec_ptr),
        .o_hd_state (w_ib_hd_state),
        .o_tl_state (w_ib_tl_state),
        .o_cnt      (w_icnt)
    );

    btc_bank_ring #(
        .NUM (pOBANK_NUM),
        .SW  (OB_SW)
    ) u_oring (
        .iclk       (iclk),
        .ireset_n   (ireset_n),
        .iclkena    (iclkena),
        .i_hd_we    (w_ob_hd_we),
        .i_hd_adv   (w_dec_acc),
        .i_hd_val   (w_ob_hd_val),
        .i_tl_adv   (w_rd_acc),
        .i_tl_val   (OB_FREE),
        .o_hd_ptr   (w_odec_ptr),
        .o_tl_ptr   (w_rd_ptr),
        .o_hd_state (w_ob_hd_state),
        .o_tl_state (w_ob_tl_state),
        .o_cnt      (w_ocnt)
    );

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            for (int i = 0; i < pIBANK_NUM; i++) r_itag[i] <= '0;
            for (int i = 0; i < pOBANK_NUM; i++) r_otag[i] <= '0;
            r_err <= 1'b0;
        end else if (iclkena) begin
            if (w_wr_acc)  r_itag[w_wr_ptr]   <= iwr_tag;
            if (w_dec_acc) r_otag[w_odec_ptr] <= r_itag[w_idec_ptr];
            if ((iwr_done && !w_wr_rdy) || (irbuf_rempty && !w_rbuf_full)
                || (ird_done && !w_rd_val))
                r_err <= 1'b1;
        end
    end

    assign owr_rdy     = w_wr_rdy;
    assign owr_bank    = w_wr_ptr;
    assign orbuf_full  = w_rbuf_full;
    assign odec_ibank  = w_idec_ptr;
    assign odec_obank  = w_odec_ptr;
    assign odec_tag    = r_itag[w_idec_ptr];
    assign owbuf_empty = (w_ob_hd_state == OB_WRITING);
    assign ord_val     = w_rd_val;
    assign ord_bank    = w_rd_ptr;
    assign ord_tag     = r_otag[w_rd_ptr];
    assign oerr        = r_err;
    assign oicnt       = w_icnt;

endmodule

// File: tb/tb_btc_dec_buf_sched.sv
// Directed bench: a 2/2-bank instance driven from a vector table plus corner
// sequences, and a 4/4-bank instance streaming nine tagged blocks.
module tb_btc_dec_buf_sched;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clkena = 1'b1;
    logic        wr_done = 1'b0;
    logic [15:0] wr_tag = 16'h0;
    logic        rempty = 1'b0;
    logic        rd_done = 1'b0;

    logic        a_owr_rdy, a_owr_bank, a_orbuf_full, a_odec_ibank, a_odec_obank;
    logic [15:0] a_odec_tag, a_ord_tag;
    logic        a_owbuf_empty, a_ord_val, a_ord_bank, a_oerr;
    logic [1:0]  a_oicnt;

    logic        b_owr_rdy, b_orbuf_full, b_owbuf_empty, b_ord_val, b_oerr;
    logic [1:0]  b_owr_bank, b_odec_ibank, b_odec_obank, b_ord_bank;
    logic [15:0] b_odec_tag, b_ord_tag;
    logic [2:0]  b_oicnt;

    always #5 clk = ~clk;

    btc_dec_buf_sched #(.pIBANK_NUM(2), .pOBANK_NUM(2), .pTAG_W(16)) u_dut2 (
        .iclk(clk), .ireset_n(rst_n), .iclkena(clkena),
        .owr_rdy(a_owr_rdy), .owr_bank(a_owr_bank), .iwr_done(wr_done), .iwr_tag(wr_tag),
        .orbuf_full(a_orbuf_full), .odec_ibank(a_odec_ibank), .odec_obank(a_odec_obank),
        .odec_tag(a_odec_tag), .owbuf_empty(a_owbuf_empty), .irbuf_rempty(rempty),
        .ord_val(a_ord_val), .ord_bank(a_ord_bank), .ord_tag(a_ord_tag), .ird_done(rd_done),
        .oerr(a_oerr), .oicnt(a_oicnt)
    );

    btc_dec_buf_sched #(.pIBANK_NUM(4), .pOBANK_NUM(4), .pTAG_W(16)) u_dut4 (
        .iclk(clk), .ireset_n(rst_n), .iclkena(clkena),
        .owr_rdy(b_owr_rdy), .owr_bank(b_owr_bank), .iwr_done(wr_done), .iwr_tag(wr_tag),
        .orbuf_full(b_orbuf_full), .odec_ibank(b_odec_ibank), .odec_obank(b_odec_obank),
        .odec_tag(b_odec_tag), .owbuf_empty(b_owbuf_empty), .irbuf_rempty(rempty),
        .ord_val(b_ord_val), .ord_bank(b_ord_bank), .ord_tag(b_ord_tag), .ird_done(rd_done),
        .oerr(b_oerr), .oicnt(b_oicnt)
    );

    typedef struct {
        logic        wr;
        logic [15:0] tag;
        logic        rem;
        logic        rd;
        logic        rdy;
        logic        bank;
        logic        rbf;
        logic        decob;
        logic [15:0] dtag;
        logic        rval;
        logic        rbank;
        logic [15:0] rtag;
        logic        err;
        logic [1:0]  icnt;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [15:0] tag, input logic rem,
                                input logic rd, input logic rdy, input logic bank,
                                input logic rbf, input logic decob, input logic [15:0] dtag,
                                input logic rval, input logic rbank, input logic [15:0] rtag,
                                input logic err, input logic [1:0] icnt);
        vec_t v;
        v.wr = wr; v.tag = tag; v.rem = rem; v.rd = rd;
        v.rdy = rdy; v.bank = bank; v.rbf = rbf; v.decob = decob; v.dtag = dtag;
        v.rval = rval; v.rbank = rbank; v.rtag = rtag; v.err = err; v.icnt = icnt;
        return v;
    endfunction

    function automatic logic [15:0] blk_tag(input int k);
        return 16'(16'h1000 + k * 16'h0111);
    endfunction

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t vecs[21];

    initial begin
        logic [40:0] act;
        logic [40:0] exp;
        int wr_n;
        int rd_n;

        // wr, tag, rem, rd | rdy, bank, rbf, decob, dtag, rval, rbank, rtag, err, icnt
        vecs[0]  = mk(L,16'h0000,L,L, H,L,L,L,16'h0000, L,L,16'h0000, L,2'd0);
        vecs[1]  = mk(H,16'h1234,L,L, H,H,L,L,16'h1234, L,L,16'h0000, L,2'd1);
        vecs[2]  = mk(L,16'h0000,L,L, H,H,H,L,16'h1234, L,L,16'h0000, L,2'd1);
        vecs[3]  = mk(L,16'h0000,H,L, H,H,L,H,16'h0000, H,L,16'h1234, L,2'd0);
        vecs[4]  = mk(L,16'h0000,L,H, H,H,L,H,16'h0000, L,H,16'h0000, L,2'd0);
        vecs[5]  = mk(H,16'hAAAA,L,L, H,L,L,H,16'hAAAA, L,H,16'h0000, L,2'd1);
        vecs[6]  = mk(H,16'hBBBB,L,L, L,H,H,H,16'hAAAA, L,H,16'h0000, L,2'd2);
        vecs[7]  = mk(H,16'hCCCC,L,L, L,H,H,H,16'hAAAA, L,H,16'h0000, H,2'd2);
        vecs[8]  = mk(L,16'h0000,H,L, H,H,L,L,16'hBBBB, H,H,16'hAAAA, H,2'd1);
        vecs[9]  = mk(L,16'h0000,L,L, H,H,H,L,16'hBBBB, H,H,16'hAAAA, H,2'd1);
        vecs[10] = mk(H,16'hDDDD,L,L, L,L,H,L,16'hBBBB, H,H,16'hAAAA, H,2'd2);
        vecs[11] = mk(L,16'h0000,H,L, H,L,L,H,16'hDDDD, H,H,16'hAAAA, H,2'd1);
        vecs[12] = mk(L,16'h0000,L,L, H,L,L,H,16'hDDDD, H,H,16'hAAAA, H,2'd1);
        vecs[13] = mk(L,16'h0000,L,H, H,L,L,H,16'hDDDD, H,L,16'hBBBB, H,2'd1);
        vecs[14] = mk(L,16'h0000,L,L, H,L,H,H,16'hDDDD, H,L,16'hBBBB, H,2'd1);
        vecs[15] = mk(H,16'hEEEE,H,H, H,H,L,L,16'hEEEE, H,H,16'hDDDD, H,2'd1);
        vecs[16] = mk(L,16'h0000,L,L, H,H,H,L,16'hEEEE, H,H,16'hDDDD, H,2'd1);
        vecs[17] = mk(L,16'h0000,H,L, H,H,L,H,16'hDDDD, H,H,16'hDDDD, H,2'd0);
        vecs[18] = mk(L,16'h0000,L,H, H,H,L,H,16'hDDDD, H,L,16'hEEEE, H,2'd0);
        vecs[19] = mk(L,16'h0000,L,H, H,H,L,H,16'hDDDD, L,H,16'hDDDD, H,2'd0);
        vecs[20] = mk(L,16'h0000,L,H, H,H,L,H,16'hDDDD, L,H,16'hDDDD, H,2'd0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            wr_done = vecs[i].wr;
            wr_tag  = vecs[i].tag;
            rempty  = vecs[i].rem;
            rd_done = vecs[i].rd;
            @(negedge clk);
            act = {a_owr_rdy, a_owr_bank, a_orbuf_full, a_odec_obank, a_odec_tag,
                   a_ord_val, a_ord_bank, a_ord_tag, a_oerr, a_oicnt};
            exp = {vecs[i].rdy, vecs[i].bank, vecs[i].rbf, vecs[i].decob, vecs[i].dtag,
                   vecs[i].rval, vecs[i].rbank, vecs[i].rtag, vecs[i].err, vecs[i].icnt};
            if (act !== exp)
                $display("FAIL vec%0d: got %h expected %h", i, act, exp);
            n_vec++;
            if (act !== exp) n_err++;
        end
        wr_done = 1'b0; rempty = 1'b0; rd_done = 1'b0;

        // Clock enable low must swallow a write pulse.
        clkena  = 1'b0;
        wr_done = 1'b1;
        wr_tag  = 16'h5555;
        @(negedge clk);
        wr_done = 1'b0;
        clkena  = 1'b1;
        @(negedge clk);
        chk("clkena_bank", 64'(a_owr_bank), 64'(1));
        chk("clkena_icnt", 64'(a_oicnt), 64'(0));

        // Reset clears the sticky error and all banks.
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_state", 64'({a_owr_rdy, a_owr_bank, a_orbuf_full, a_owbuf_empty, a_ord_val,
                              a_oerr, a_oicnt, a_odec_tag, a_ord_tag}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0}));
        rst_n = 1'b1;
        @(negedge clk);

        // Decode-done with nothing to decode is a protocol error.
        rempty = 1'b1;
        @(negedge clk);
        rempty = 1'b0;
        chk("err_rempty", 64'(a_oerr), 64'(1));
        chk("err_rempty_icnt", 64'(a_oicnt), 64'(0));

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Nine blocks through the 4/4 instance, reader throttled to build back-pressure.
        wr_n = 0;
        rd_n = 0;
        for (int cyc = 0; cyc < 400 && rd_n < 9; cyc++) begin
            wr_done = (wr_n < 9) && b_owr_rdy;
            if (wr_done) begin
                chk("wrap_wr_bank", 64'(b_owr_bank), 64'(wr_n % 4));
                wr_tag = blk_tag(wr_n);
                wr_n++;
            end
            rempty  = b_orbuf_full && (cyc % 2 == 0);
            rd_done = b_ord_val && (cyc % 3 == 0);
            if (rd_done) begin
                chk("wrap_rd_tag", 64'(b_ord_tag), 64'(blk_tag(rd_n)));
                rd_n++;
            end
            @(negedge clk);
        end
        wr_done = 1'b0; rempty = 1'b0; rd_done = 1'b0;
        chk("wrap_blocks_read", 64'(rd_n), 64'(9));
        @(negedge clk);
        chk("wrap_err", 64'(b_oerr), 64'(0));
        chk("wrap_idle", 64'({b_ord_val, b_orbuf_full, b_oicnt}), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
